// File: rtl/core_config.sv
// Core-wide sizing constants shared by the frontend blocks.
package core_config;
    localparam int FRONTEND_FTQ_SIZE = 8;
    localparam int COMMIT_WIDTH      = 2;
endpackage

// File: rtl/frontend_types.sv
// Types exchanged between the branch predictor, the fetch target queue and the fetch unit.
package frontend_types;
    import core_config::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] start_pc;
        logic [2:0]  length;
        logic        predicted_taken;
    } ftq_block_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] start_pc;
        logic        predicted_taken;
    } ftq_commit_t;

    typedef logic [$clog2(FRONTEND_FTQ_SIZE):0] ftq_ptr_t;
endpackage

// File: rtl/ftq.sv
// Fetch target queue: buffers predicted fetch blocks, issues them in order to fetch,
// retires on backend commit and rolls back to a flushing block.
module ftq
    import frontend_types::*;
#(
    parameter int SIZE         = core_config::FRONTEND_FTQ_SIZE,
    parameter int COMMIT_WIDTH = core_config::COMMIT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  ftq_block_t                          bpu_i,
    output logic                                bpu_ready_o,
    output ftq_block_t                          ifu_o,
    output logic [$clog2(SIZE)-1:0]             ifu_ftq_id_o,
    input  logic                                ifu_accept_i,
    input  logic [COMMIT_WIDTH-1:0]             backend_commit_block_i,
    input  logic                                backend_flush_i,
    input  logic [$clog2(SIZE)-1:0]             backend_flush_ftq_id_i,
    output ftq_commit_t [COMMIT_WIDTH-1:0]      commit_o,
    output logic [$clog2(SIZE):0]               occupancy_o,
    output logic                                flush_err_o
);
    localparam int IW = $clog2(SIZE);
    localparam int PW = IW + 1;

    logic [PW-1:0] bpu_ptr_q, bpu_ptr_d;
    logic [PW-1:0] ifu_ptr_q, ifu_ptr_d;
    logic [PW-1:0] comm_ptr_q, comm_ptr_d;
    logic          flush_err_q, flush_err_d;
    ftq_block_t    mem_q [SIZE];

    logic [PW-1:0] occ, issued, pop, n_commit;
    logic [IW-1:0] flush_d;
    logic          full, flush_legal, enq, iss;

    always_comb begin
        occ         = bpu_ptr_q - comm_ptr_q;
        issued      = ifu_ptr_q - comm_ptr_q;
        full        = (occ == PW'(SIZE));
        pop         = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++)
            pop = pop + PW'(backend_commit_block_i[i]);
        // Only blocks already handed to fetch may retire.
        n_commit    = (pop > issued) ? issued : pop;
        flush_d     = backend_flush_ftq_id_i - comm_ptr_q[IW-1:0];
        flush_legal = ({1'b0, flush_d} < issued);
        enq         = bpu_i.valid & ~full & ~backend_flush_i;
        iss         = ifu_o.valid & ifu_accept_i;
    end

    always_comb begin
        bpu_ptr_d   = bpu_ptr_q;
        ifu_ptr_d   = ifu_ptr_q;
        comm_ptr_d  = comm_ptr_q + n_commit;
        flush_err_d = flush_err_q;
        if (backend_flush_i) begin
            // Roll back just behind the flushing block, measured from pre-commit comm_ptr.
            if (flush_legal) begin
                bpu_ptr_d = comm_ptr_q + {1'b0, flush_d} + PW'(1);
                ifu_ptr_d = comm_ptr_q + {1'b0, flush_d} + PW'(1);
            end else begin
                flush_err_d = 1'b1;
            end
        end else begin
            if (enq) bpu_ptr_d = bpu_ptr_q + PW'(1);
            if (iss) ifu_ptr_d = ifu_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bpu_ptr_q   <= '0;
            ifu_ptr_q   <= '0;
            comm_ptr_q  <= '0;
            flush_err_q <= 1'b0;
        end else begin
            bpu_ptr_q   <= bpu_ptr_d;
            ifu_ptr_q   <= ifu_ptr_d;
            comm_ptr_q  <= comm_ptr_d;
            flush_err_q <= flush_err_d;
        end
    end

    // Entry contents need no reset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (enq) mem_q[bpu_ptr_q[IW-1:0]] <= bpu_i;
    end

    always_comb begin
        ifu_o       = mem_q[ifu_ptr_q[IW-1:0]];
        ifu_o.valid = (ifu_ptr_q != bpu_ptr_q) & ~backend_flush_i;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            commit_o[k].valid           = (PW'(k) < n_commit);
            commit_o[k].start_pc        = mem_q[comm_ptr_q[IW-1:0] + IW'(k)].start_pc;
            commit_o[k].predicted_taken = mem_q[comm_ptr_q[IW-1:0] + IW'(k)].predicted_taken;
        end
    end

    assign ifu_ftq_id_o = ifu_ptr_q[IW-1:0];
    assign bpu_ready_o  = ~full;
    assign occupancy_o  = occ;
    assign flush_err_o  = flush_err_q;
endmodule

// File: tb/tb_ftq.sv
// Randomized and directed bench for ftq against a queue-based reference model.
module tb_ftq;
    import frontend_types::*;
    localparam int SIZE = 8;
    localparam int CW   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    ftq_block_t          bpu_i;
    logic                bpu_ready_o;
    ftq_block_t          ifu_o;
    logic [2:0]          ifu_ftq_id_o;
    logic                ifu_accept_i;
    logic [CW-1:0]       backend_commit_block_i;
    logic                backend_flush_i;
    logic [2:0]          backend_flush_ftq_id_i;
    ftq_commit_t [CW-1:0] commit_o;
    logic [3:0]          occupancy_o;
    logic                flush_err_o;

    always #5 clk = ~clk;

    ftq #(.SIZE(SIZE), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bpu_i(bpu_i), .bpu_ready_o(bpu_ready_o),
        .ifu_o(ifu_o), .ifu_ftq_id_o(ifu_ftq_id_o), .ifu_accept_i(ifu_accept_i),
        .backend_commit_block_i(backend_commit_block_i), .backend_flush_i(backend_flush_i),
        .backend_flush_ftq_id_i(backend_flush_ftq_id_i), .commit_o(commit_o),
        .occupancy_o(occupancy_o), .flush_err_o(flush_err_o));

    // Model: unretired blocks oldest-first, how many of them are issued, how many retired so far.
    ftq_block_t mq[$];
    int m_iss, m_ret, m_err;
    int n_chk, n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int n_retire();
        int pop = $countones(backend_commit_block_i);
        return (pop < m_iss) ? pop : m_iss;
    endfunction

    task automatic check_outputs();
        int occ = mq.size();
        int n = n_retire();
        bit iv = (m_iss < occ) && !backend_flush_i;
        check("ready", 64'(bpu_ready_o), 64'(occ < SIZE));
        check("occupancy", 64'(occupancy_o), 64'(occ));
        check("ifu_valid", 64'(ifu_o.valid), 64'(iv));
        if (iv) begin
            check("ifu_pc", 64'(ifu_o.start_pc), 64'(mq[m_iss].start_pc));
            check("ifu_len", 64'(ifu_o.length), 64'(mq[m_iss].length));
            check("ifu_taken", 64'(ifu_o.predicted_taken), 64'(mq[m_iss].predicted_taken));
            check("ifu_id", 64'(ifu_ftq_id_o), 64'((m_ret + m_iss) % SIZE));
        end
        for (int k = 0; k < CW; k++) begin
            check("commit_valid", 64'(commit_o[k].valid), 64'(k < n));
            if (k < n) begin
                check("commit_pc", 64'(commit_o[k].start_pc), 64'(mq[k].start_pc));
                check("commit_taken", 64'(commit_o[k].predicted_taken), 64'(mq[k].predicted_taken));
            end
        end
        check("flush_err", 64'(flush_err_o), 64'(m_err));
    endtask

    task automatic model_update();
        int n = n_retire();
        if (backend_flush_i) begin
            int d = (int'(backend_flush_ftq_id_i) - (m_ret % SIZE) + SIZE) % SIZE;
            if (d < m_iss) begin
                while (mq.size() > d + 1) void'(mq.pop_back());
                m_iss = d + 1;
            end else begin
                m_err = 1;
            end
        end else begin
            bit do_iss = (m_iss < mq.size()) && ifu_accept_i;
            if (bpu_i.valid && mq.size() < SIZE) mq.push_back(bpu_i);
            if (do_iss) m_iss++;
        end
        repeat (n) void'(mq.pop_front());
        m_iss -= n;
        m_ret += n;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc, input logic [2:0] len, input bit tk,
                          input bit acc, input logic [CW-1:0] cmt, input bit fl, input logic [2:0] fid);
        bpu_i.valid = v; bpu_i.start_pc = pc; bpu_i.length = len; bpu_i.predicted_taken = tk;
        ifu_accept_i = acc; backend_commit_block_i = cmt;
        backend_flush_i = fl; backend_flush_ftq_id_i = fid;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [2:0] len, input bit tk,
                         input bit acc, input logic [CW-1:0] cmt, input bit fl, input logic [2:0] fid);
        set_in(v, pc, len, tk, acc, cmt, fl, fid);
        step();
    endtask

    task automatic do_reset();
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        mq.delete(); m_iss = 0; m_ret = 0; m_err = 0;
        #2;
        check("rst_occupancy", 64'(occupancy_o), 64'(0));
        check("rst_ready", 64'(bpu_ready_o), 64'(1));
        check("rst_ifu_valid", 64'(ifu_o.valid), 64'(0));
        check("rst_commit_valid", 64'({commit_o[1].valid, commit_o[0].valid}), 64'(0));
        check("rst_flush_err", 64'(flush_err_o), 64'(0));
        #1 rst = 1'b1;
    endtask

    initial begin
        int guard, enq_cnt;
        n_chk = 0; n_fail = 0;
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();

        // Fill with fetch stalled; the ninth block must be held back.
        for (int i = 0; i < 8; i++) drive(1, 32'h1c000000 + 32'(16 * i), 3'd4, 0, 0, 0, 0, 0);
        check("fill_occ", 64'(occupancy_o), 64'(8));
        check("fill_ready", 64'(bpu_ready_o), 64'(0));
        drive(1, 32'h1c000080, 3'd4, 0, 0, 0, 0, 0);
        check("fill_held_occ", 64'(occupancy_o), 64'(8));

        // Issue everything, then retire two per cycle.
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            set_in(0, 0, 1, 0, 0, 2'b11, 0, 0);
            #1;
            check("retire_pc0", 64'(commit_o[0].start_pc), 64'(32'h1c000000 + 32'(32 * c)));
            check("retire_pc1", 64'(commit_o[1].start_pc), 64'(32'h1c000010 + 32'(32 * c)));
            step();
        end
        check("drain_occ", 64'(occupancy_o), 64'(0));
        check("drain_ready", 64'(bpu_ready_o), 64'(1));

        // Legal flush on slot 2 with the oldest block retiring in the same cycle.
        do_reset();
        for (int i = 0; i < 6; i++) drive(1, 32'h1c001000 + 32'(16 * i), 3'd2, i[0], 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 1, 0, 0, 0);
        set_in(0, 0, 1, 0, 0, 2'b01, 1, 3'd2);
        #1;
        check("lflush_commit_v", 64'(commit_o[0].valid), 64'(1));
        check("lflush_commit_pc", 64'(commit_o[0].start_pc), 64'(32'h1c001000));
        step();
        check("lflush_occ", 64'(occupancy_o), 64'(2));
        check("lflush_ifu_valid", 64'(ifu_o.valid), 64'(0));
        check("lflush_ifu_id", 64'(ifu_ftq_id_o), 64'(3));

        // Stream 13 blocks through, then flush a wrapped slot.
        do_reset();
        enq_cnt = 0; guard = 0;
        while (m_ret < 13 && guard < 100) begin
            drive(enq_cnt < 13, 32'h1c002000 + 32'(4 * enq_cnt), 3'd1, 0, 1, 2'b01, 0, 0);
            if (enq_cnt < 13) enq_cnt++;
            guard++;
        end
        check("wrap_stream_done", 64'(m_ret), 64'(13));
        for (int i = 0; i < 5; i++) drive(1, 32'h1c003000 + 32'(16 * i), 3'd3, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 0, 0);
        check("wrap_occ_pre", 64'(occupancy_o), 64'(5));
        drive(0, 0, 1, 0, 0, 2'b01, 1, 3'd1);
        check("wrap_occ_post", 64'(occupancy_o), 64'(4));
        check("wrap_ifu_id", 64'(ifu_ftq_id_o), 64'(2));

        // Flush beats a simultaneous enqueue.
        drive(1, 32'hdeadbee0, 3'd4, 0, 1, 0, 1, 3'd7);
        check("fvse_occ", 64'(occupancy_o), 64'(2));
        drive(0, 0, 1, 0, 0, 0, 0, 0);

        // Illegal flush: only slots 0-1 issued.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 32'h1c004000 + 32'(16 * i), 3'd4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 1, 3'd5);
        check("iflush_err", 64'(flush_err_o), 64'(1));
        check("iflush_occ", 64'(occupancy_o), 64'(4));
        check("iflush_ifu_id", 64'(ifu_ftq_id_o), 64'(2));
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 2'b01, 0, 0);
        check("iflush_sticky", 64'(flush_err_o), 64'(1));

        // Random traffic with a mid-run reset; out-of-range flushes only late in the run.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit v, tk, acc, fl;
            logic [31:0] pc;
            logic [2:0] len, fid;
            logic [CW-1:0] cmt;
            if (cyc == 1500) do_reset();
            v = ($urandom % 4) != 0;
            pc = $urandom & 32'hffff_fffc;
            len = 3'(1 + $urandom % 4);
            tk = 1'($urandom % 2);
            acc = ($urandom % 3) != 0;
            cmt = CW'($urandom % 4);
            fl = ($urandom % 20) == 0;
            fid = 0;
            if (fl) begin
                if (m_iss > 0 && (cyc < 2000 || ($urandom % 8) != 0)) begin
                    int d = $urandom % m_iss;
                    fid = 3'((m_ret + d) % SIZE);
                    if (d == 0) cmt = ($urandom % 2) ? 2'b01 : 2'b00;
                end else if (cyc >= 2000) begin
                    fid = 3'($urandom % SIZE);
                    cmt = 0;
                end else begin
                    fl = 0;
                end
            end
            drive(v, pc, len, tk, acc, cmt, fl, fid);
        end

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ftq.md
# ftq

Fetch target queue between the branch predictor (BPU) and instruction fetch (IFU). Buffers predicted fetch blocks in a circular queue and issues them in order to the IFU. Retires blocks when the backend commit controller reports `backend_commit_block`, and rolls back on `backend_flush_ftq_id` so that speculative blocks behind a flushing block are discarded. It also supplies committed block PCs to the predictor for training.

## Interface
- `SIZE`, default `FRONTEND_FTQ_SIZE` (8): entry count; must be a power of two, at least 4.
- `COMMIT_WIDTH`, default `COMMIT_WIDTH` (2): blocks retirable per cycle.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: asynchronous, active-low reset.
- `bpu_i` in, `ftq_block_t`: `{valid, start_pc[31:0], length[2:0], predicted_taken}`; `length` is 1..4 instructions.
- `bpu_ready_o` out, 1: queue not full.
- `ifu_o` out, `ftq_block_t`: block at the IFU pointer. `valid` indicates the block is available.
- `ifu_ftq_id_o` out, log2(SIZE): slot index of `ifu_o`.
- `ifu_accept_i` in, 1: IFU takes `ifu_o` this cycle.
- `backend_commit_block_i` in, COMMIT_WIDTH: per-lane "a basic block retired".
- `backend_flush_i` in, 1: backend flush (exception, ertn, idle, refetch).
- `backend_flush_ftq_id_i` in, log2(SIZE): slot of the flushing block.
- `commit_o` out, [COMMIT_WIDTH] of `{valid, start_pc, predicted_taken}`: retired blocks, in order, for BPU training.
- `occupancy_o` out, log2(SIZE)+1: occupied entry count.
- `flush_err_o` out, 1: sticky; set on an out-of-range flush id.

## Operation
- **Pointers.** `bpu_ptr` (write), `ifu_ptr` (issue), and `comm_ptr` (retire) are each log2(SIZE)+1 bits wide, with the MSB as the wrap bit.
  - Invariant: `comm_ptr <= ifu_ptr <= bpu_ptr`, where ordering is measured as distance from `comm_ptr`.
- **Full and empty.**
  - `occupancy = bpu_ptr - comm_ptr`, taken modulo 2·SIZE.
  - Full when `occupancy == SIZE`.
  - `bpu_ready_o = !full`. It does not depend on `bpu_i.valid`.
- **Enqueue.** When `bpu_i.valid & bpu_ready_o & !backend_flush_i`, write the entry at `bpu_ptr` and increment `bpu_ptr`.
- **Issue.**
  - `ifu_o.valid = (ifu_ptr != bpu_ptr) & !backend_flush_i`.
  - `ifu_o` fields are read combinationally from slot `ifu_ptr`.
  - When `ifu_o.valid & ifu_accept_i`, increment `ifu_ptr`.
- **Commit.**
  - `n = popcount(backend_commit_block_i)`; the lane pattern is irrelevant.
  - `n` is clamped to `ifu_ptr - comm_ptr`; only issued blocks retire.
  - `commit_o[k].valid = (k < n)`. `commit_o[k]` carries slot `comm_ptr + k`.
  - Advance `comm_ptr` by `n`.
- **Flush.**
  - Let `d = (backend_flush_ftq_id_i - comm_ptr[idx])` mod SIZE.
  - Legal when `d < ifu_ptr - comm_ptr`. In that case, set `bpu_ptr` and `ifu_ptr` to `comm_ptr + d + 1`. All younger blocks are discarded.
  - Illegal (`d` out of range): the pointers are unchanged and `flush_err_o` is set. It stays set until reset.
- **Simultaneous flush and commit.** Both are applied. Commit uses the pre-flush pointers. `d` is computed from the pre-commit `comm_ptr`.
  - The flushing block normally retires in the same cycle (commit lane 0 set).
  - After that, `comm_ptr` may equal the new `bpu_ptr`, leaving the queue empty.
- **Flush priority.** Flush overrides enqueue and issue in its cycle. Any `bpu_i` presented that cycle is dropped, and the BPU must re-present from the redirect PC.

## Timing
- All outputs are combinational from registered pointers and the entry RAM.
- Reset values:
  - Pointers 0 and `occupancy_o` 0.
  - `bpu_ready_o` 1.
  - `ifu_o.valid` 0.
  - `commit_o[*].valid` 0.
  - `flush_err_o` 0.
  - Entry contents are don't-care.
- Latency:
  - Enqueue to `ifu_o.valid`: 1 cycle. There is no bypass.
  - Accept to retire: at least 1 cycle.
- Throughput: 1 enqueue, 1 issue, and COMMIT_WIDTH retires per cycle, concurrently.
- Full boundary: an enqueue and a retire in the same cycle while full are both legal only if `bpu_ready_o` was 1 that cycle. Ready uses current-cycle occupancy, with no look-ahead.
- Reset mid-operation: pointers clear immediately (asynchronous), so all in-flight blocks are lost.

## Structure
- Shared package `frontend_types`:
  - `ftq_block_t`
  - `ftq_commit_t`
  - pointer type `ftq_ptr_t` (log2(SIZE)+1 bits)
- `SIZE` and `COMMIT_WIDTH` come from `core_config`.
- Single module; entry storage is a register array. No sub-module.

## Test plan
- **Fill.** Reset, then enqueue 8 blocks with PCs 0x1c000000 + 16·i and IFU stalled. Required: `bpu_ready_o` = 0 after the 8th; the 9th is held; `occupancy_o` = 8.
- **Issue and retire.** Issue all 8, then drive commit `2'b11` for 4 cycles. Required: `commit_o` shows PC pairs (0x1c000000, 0x1c000010) … (0x1c000060, 0x1c000070); empty at the end; `bpu_ready_o` = 1.
- **Legal flush.** Enqueue 6 and issue 5, then flush with id 2 and commit `2'b01` in the same cycle. Required: slot 0 retires; `ifu_ptr = bpu_ptr = 3`; `occupancy_o` = 2; `ifu_o.valid` = 0.
- **Wrap-around.** Cycle 13 blocks through the queue, then flush with id 1 (wrapped). Required: pointers compare correctly across the wrap bit; the occupancy after flush matches the model.
- **Flush versus enqueue.** Flush and `bpu_i.valid` in the same cycle. Required: the block is not written, and `occupancy_o` reflects the flush only.
- **Illegal flush.** Flush with id 5 while only slots 0–1 are issued. Required: pointers unchanged; `flush_err_o` = 1 until `rst` goes low.
